divu_ctl: RTL and testbench

Multi-cycle controller for unsigned divide and the HI/LO register pair in the 5-stage pipeline's EX stage. It consumes the 2-bit `signal` code from ALU control (00 divu, 10 mfhi, 01 mflo, 11 none). It sequences a radix-2 restoring divide over WIDTH cycles, owns HI/LO, and serves mfhi/mflo reads. It raises a stall to the hazard unit whenever an EX instruction needs the unit while a divide is in flight.

---
 rtl/divu_ctl.sv | 127 ++++++++++++
 tb/tb_divu_ctl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/divu_ctl.sv
// Multi-cycle unsigned divide controller for the EX stage: owns HI/LO, runs a
// radix-2 restoring divide over WIDTH cycles, and stalls EX users while busy.
module divu_ctl #(
  parameter int unsigned          WIDTH   = 32,
  parameter int unsigned          CNT_W   = 5,
  parameter logic [WIDTH-1:0]     DZ_QUOT = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic [1:0]       signal,
  input  logic             flush,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             stall,
  output logic             busy,
  output logic [WIDTH-1:0] hilo_out,
  output logic             div_zero,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_ZDIV,
    S_DONE
  } state_t;

  localparam logic [1:0] SIG_DIVU = 2'b00;
  localparam logic [1:0] SIG_MFLO = 2'b01;
  localparam logic [1:0] SIG_MFHI = 2'b10;
  localparam logic [1:0] SIG_NONE = 2'b11;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   rem, quo, dsr;
  logic [WIDTH-1:0]   hi, lo;
  logic [CNT_W-1:0]   cnt;

  logic               accept;
  logic               last;
  logic               take;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     rem_sub;
  logic [WIDTH-1:0]   rem_nxt, quo_nxt;

  // DONE is not busy, so a divu that retires there is accepted as from IDLE.
  assign accept = ex_valid && (signal == SIG_DIVU) && !flush &&
                  ((state == S_IDLE) || (state == S_DONE));
  assign last   = (cnt == CNT_W'(WIDTH - 1));

  // One restoring step; the shifted remainder needs WIDTH+1 bits when the
  // divisor has its MSB set.
  assign rem_sh  = {rem, quo[WIDTH-1]};
  assign rem_sub = rem_sh - {1'b0, dsr};
  assign take    = (rem_sh >= {1'b0, dsr});
  assign rem_nxt = take ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign quo_nxt = {quo[WIDTH-2:0], take};

  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE, S_DONE: begin
        state_nxt = S_IDLE;
        if (accept) state_nxt = (divisor == '0) ? S_ZDIV : S_RUN;
      end
      S_RUN: begin
        if (flush)     state_nxt = S_IDLE;
        else if (last) state_nxt = S_DONE;
      end
      S_ZDIV:  state_nxt = flush ? S_IDLE : S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: all datapath registers, HI/LO included, are reset; a reset mid-divide
  // must leave no stale partial result visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem      <= '0;
      quo      <= '0;
      dsr      <= '0;
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
    end else if (accept) begin
      quo <= dividend;
      dsr <= divisor;
      rem <= '0;
      cnt <= '0;
    end else if ((state == S_RUN) && !flush) begin
      rem <= rem_nxt;
      quo <= quo_nxt;
      cnt <= cnt + CNT_W'(1);
      if (last) begin
        hi       <= rem_nxt;
        lo       <= quo_nxt;
        div_zero <= 1'b0;
      end
    end else if ((state == S_ZDIV) && !flush) begin
      hi       <= quo;
      lo       <= DZ_QUOT;
      div_zero <= 1'b1;
    end
  end

  assign busy  = (state == S_RUN) || (state == S_ZDIV);
  assign done  = (state == S_DONE);
  assign stall = ex_valid && busy && (signal != SIG_NONE);

  always_comb begin
    hilo_out = '0;
    if (!stall) begin
      if (signal == SIG_MFHI)      hilo_out = hi;
      else if (signal == SIG_MFLO) hilo_out = lo;
    end
  end

endmodule

// File: tb/tb_divu_ctl.sv
// Directed bench for divu_ctl: an arithmetic HI/LO model with a latency
// countdown is compared every cycle, plus literal expectations per scenario.
module tb_divu_ctl;

  localparam int W = 32;

  logic          clk;
  logic          rst_n;
  logic          ex_valid;
  logic [1:0]    signal;
  logic          flush;
  logic [W-1:0]  dividend;
  logic [W-1:0]  divisor;
  logic          stall;
  logic          busy;
  logic [W-1:0]  hilo_out;
  logic          div_zero;
  logic          done;

  int n_tests = 0;
  int n_fail  = 0;

  divu_ctl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ex_valid (ex_valid),
    .signal   (signal),
    .flush    (flush),
    .dividend (dividend),
    .divisor  (divisor),
    .stall    (stall),
    .busy     (busy),
    .hilo_out (hilo_out),
    .div_zero (div_zero),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: busy lasts WIDTH cycles (or 1 for a zero divisor) after the issue
  // edge, then results land in HI/LO and done shows for one cycle.
  int            m_left;
  bit            m_done;
  logic [W-1:0]  m_hi, m_lo, p_hi, p_lo;
  bit            m_dz, p_dz;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0; m_done = 0;
      m_hi = '0; m_lo = '0; m_dz = 0;
      p_hi = '0; p_lo = '0; p_dz = 0;
    end else begin
      m_done = 0;
      if (m_left > 0) begin
        if (flush) m_left = 0;
        else begin
          m_left--;
          if (m_left == 0) begin
            m_hi = p_hi; m_lo = p_lo; m_dz = p_dz; m_done = 1;
          end
        end
      end else if (ex_valid && signal == 2'b00 && !flush) begin
        if (divisor == '0) begin
          p_hi = dividend; p_lo = '1; p_dz = 1; m_left = 1;
        end else begin
          p_hi = dividend % divisor; p_lo = dividend / divisor; p_dz = 0; m_left = W;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      logic          e_busy, e_stall;
      logic [W-1:0]  e_out;
      e_busy  = (m_left > 0);
      e_stall = ex_valid && e_busy && (signal != 2'b11);
      e_out   = '0;
      if (!e_stall && signal == 2'b10) e_out = m_hi;
      if (!e_stall && signal == 2'b01) e_out = m_lo;
      check("cyc_busy",     busy,     e_busy);
      check("cyc_stall",    stall,    e_stall);
      check("cyc_done",     done,     m_done);
      check("cyc_hilo_out", hilo_out, e_out);
      check("cyc_div_zero", div_zero, m_dz);
    end
  end

  task automatic drive(input logic ev, input logic [1:0] sig, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic fl);
    ex_valid = ev; signal = sig; dividend = a; divisor = b; flush = fl;
  endtask

  task automatic drive_idle();
    drive(1'b0, 2'b11, '0, '0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a divu for one cycle; returns just after the accepting edge.
  task automatic start_div(input logic [W-1:0] a, input logic [W-1:0] b);
    step();
    drive(1'b1, 2'b00, a, b, 1'b0);
    step();
    drive_idle();
  endtask

  // Observe a fixed 40-cycle window, counting busy and done cycles.
  task automatic watch(output int nb, output int nd);
    nb = 0; nd = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) nb++;
      if (done) nd++;
    end
  endtask

  task automatic read(input logic [1:0] sig, input logic [W-1:0] exp, input string name);
    step();
    drive(1'b1, sig, '0, '0, 1'b0);
    @(negedge clk);
    check(name, hilo_out, exp);
  endtask

  initial begin
    int nb, nd, ns;
    rst_n = 1'b0;
    drive(1'b1, 2'b10, '0, '0, 1'b0);
    #12;
    check("rst_busy",     busy,     1'b0);
    check("rst_stall",    stall,    1'b0);
    check("rst_done",     done,     1'b0);
    check("rst_div_zero", div_zero, 1'b0);
    check("rst_hi",       hilo_out, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive_idle();

    // Basic divide
    start_div(32'd100, 32'd7);
    watch(nb, nd);
    check("t1_busy_cycles", nb, 32);
    check("t1_done_pulses", nd, 1);
    read(2'b10, 32'd2,  "t1_hi");
    read(2'b01, 32'd14, "t1_lo");
    check("t1_div_zero", div_zero, 1'b0);

    // Early mflo stalls until the DONE cycle; presented one cycle after the
    // first RUN cycle, so 31 stall cycles remain
    start_div(32'hFFFF_FFFF, 32'h10);
    step();
    drive(1'b1, 2'b01, '0, '0, 1'b0);
    ns = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!stall) break;
      ns++;
    end
    check("t2_stall_cycles", ns, 31);
    check("t2_lo_after_stall", hilo_out, 32'h0FFF_FFFF);
    check("t2_done_with_read", done, 1'b1);
    read(2'b10, 32'hF, "t2_hi");

    // Divide by zero, then a normal divide clears div_zero
    start_div(32'd1234, 32'd0);
    watch(nb, nd);
    check("t3_busy_cycles", nb, 1);
    check("t3_done_pulses", nd, 1);
    read(2'b10, 32'd1234, "t3_hi");
    read(2'b01, 32'hFFFF_FFFF, "t3_lo");
    check("t3_div_zero", div_zero, 1'b1);
    start_div(32'd9, 32'd3);
    watch(nb, nd);
    check("t3_div_zero_clr", div_zero, 1'b0);
    read(2'b01, 32'd3, "t3_lo2");
    read(2'b10, 32'd0, "t3_hi2");

    // Flush on RUN cycle 10 aborts without touching HI/LO
    start_div(32'd50, 32'd8);
    watch(nb, nd);
    start_div(32'd1000, 32'd3);
    repeat (9) step();
    drive(1'b0, 2'b11, '0, '0, 1'b1);
    step();
    drive_idle();
    @(negedge clk);
    check("t4_busy_after_flush", busy, 1'b0);
    watch(nb, nd);
    check("t4_no_done", nd, 0);
    read(2'b10, 32'd2, "t4_hi");
    read(2'b01, 32'd6, "t4_lo");

    // Reset mid-divide (with div_zero previously set)
    start_div(32'd7, 32'd0);
    watch(nb, nd);
    start_div(32'd1000, 32'd3);
    repeat (19) step();
    drive(1'b1, 2'b01, '0, '0, 1'b0);
    @(negedge clk);
    check("t5_stall_before_rst", stall, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    check("t5_busy", busy, 1'b0);
    check("t5_stall", stall, 1'b0);
    check("t5_lo_in_rst", hilo_out, 32'h0);
    check("t5_div_zero", div_zero, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drive_idle();
    read(2'b01, 32'd0, "t5_lo");
    read(2'b10, 32'd0, "t5_hi");

    // Bubble with divu code starts nothing
    step();
    drive(1'b0, 2'b00, 32'd5, 32'd1, 1'b0);
    step();
    drive_idle();
    @(negedge clk);
    check("t6_bubble_no_start", busy, 1'b0);

    // Non-stalling traffic during RUN; a second divu does stall
    start_div(32'd20, 32'd4);
    drive(1'b1, 2'b11, '0, '0, 1'b0);
    @(negedge clk);
    check("t6_add_no_stall", stall, 1'b0);
    step();
    drive(1'b0, 2'b10, '0, '0, 1'b0);
    @(negedge clk);
    check("t6_bubble_no_stall", stall, 1'b0);
    step();
    drive(1'b1, 2'b00, 32'd1, 32'd1, 1'b0);
    @(negedge clk);
    check("t6_divu_stalls", stall, 1'b1);
    step();
    drive_idle();
    watch(nb, nd);
    check("t6_done_pulses", nd, 1);
    read(2'b01, 32'd5, "t6_lo_20_4");

    start_div(32'd3, 32'd5);
    watch(nb, nd);
    read(2'b01, 32'd0, "t6_lo_small");
    read(2'b10, 32'd3, "t6_hi_small");

    start_div(32'hDEAD_BEEF, 32'd1);
    watch(nb, nd);
    read(2'b01, 32'hDEAD_BEEF, "div1_lo");
    read(2'b10, 32'd0, "div1_hi");

    start_div(32'hFFFF_FFFF, 32'h8000_0001);
    watch(nb, nd);
    read(2'b01, 32'd1, "bigdiv_lo");
    read(2'b10, 32'h7FFF_FFFE, "bigdiv_hi");

    step();
    drive_idle();
    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
